// File: rtl/stage_fifo_pkg.sv
// stage_fifo_pkg
// Shared definitions for the stage_fifo elastic buffer:
//   STAGE_FIFO_MAX_DEPTH - largest supported DEPTH
//   cnt_op_e             - occupancy counter operation selected each cycle
//   ptr_width()          - pointer width for a given DEPTH (at least 1 bit)
package stage_fifo_pkg;

  localparam int STAGE_FIFO_MAX_DEPTH = 64;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

  // A single-entry buffer still needs a 1-bit pointer so vectors stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage_fifo_if.sv
// stage_fifo_if
// valid/rdy link through a stage_fifo. Signal names are given from the
// buffer's point of view.
//   master : the stage environment (drives src_valid/src_data and dst_rdy)
//   slave  : the stage_fifo itself (drives src_rdy and dst_valid/dst_data)
interface stage_fifo_if #(
  parameter int DW = 32
);

  logic          src_valid_in;
  logic [DW-1:0] src_data_in;
  logic          src_rdy_out;
  logic          dst_valid_out;
  logic [DW-1:0] dst_data_out;
  logic          dst_rdy_in;

  modport master (
    output src_valid_in, src_data_in, dst_rdy_in,
    input  src_rdy_out, dst_valid_out, dst_data_out
  );

  modport slave (
    input  src_valid_in, src_data_in, dst_rdy_in,
    output src_rdy_out, dst_valid_out, dst_data_out
  );

endinterface

// File: rtl/stage_fifo_ptr.sv
// stage_fifo_ptr
// Modulo-DEPTH pointer. DEPTH need not be a power of two, so the wrap from
// DEPTH-1 to 0 is explicit.
//   clk_in   - clock
//   reset_in - asynchronous active-low reset (pointer -> 0)
//   clr_in   - synchronous clear (pointer -> 0), wins over inc_in
//   inc_in   - advance by one entry
//   ptr_out  - current pointer
module stage_fifo_ptr
  import stage_fifo_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             clr_in,
  input  logic             inc_in,
  output logic [PTR_W-1:0] ptr_out
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ptr_out <= '0;
    end else if (clr_in) begin
      ptr_out <= '0;
    end else if (inc_in) begin
      ptr_out <= (ptr_out == LAST) ? '0 : ptr_out + 1'b1;
    end
  end

endmodule

// File: rtl/stage_fifo.sv
// stage_fifo
// Elastic DEPTH x DW buffer for a valid/rdy link between pipeline stages.
// src_rdy depends only on registered occupancy and flush, so there is no
// combinational path from dst_rdy to src_rdy.
//   clk_in      - clock
//   reset_in    - asynchronous active-low reset (contents dropped)
//   flush_in    - synchronous flush; masks both handshakes this cycle
//   peak_clr_in - synchronous clear of the high-water mark
//   link        - slave side of stage_fifo_if (src_* in, dst_* out)
//   count_out   - occupancy
//   full_out    - occupancy == DEPTH
//   empty_out   - occupancy == 0
//   peak_out    - highest occupancy since reset or last peak clear
// Optional: define STAGE_FIFO_BYPASS_EN to let an item cross an empty buffer
// combinationally (not stored when dst_rdy accepts it the same cycle).
module stage_fifo
  import stage_fifo_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             peak_clr_in,
  stage_fifo_if.slave      link,
  output logic [CNT_W-1:0] count_out,
  output logic             full_out,
  output logic             empty_out,
  output logic [CNT_W-1:0] peak_out
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] peak_q;
  logic [CNT_W-1:0] peak_next;
  logic             full;
  logic             empty;
  logic             src_rdy;
  logic             dst_valid;
  logic [DW-1:0]    dst_data;
  logic             push;
  logic             pop;
  logic             write_en;
  logic             read_en;
  cnt_op_e          cnt_op;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign src_rdy = !full && !flush_in;
  assign push    = link.src_valid_in && src_rdy;

`ifdef STAGE_FIFO_BYPASS_EN
  // While empty the upstream item is shown directly downstream; if it is
  // taken in the same cycle it never touches storage.
  assign dst_valid = (!empty || link.src_valid_in) && !flush_in;
  assign dst_data  = empty ? link.src_data_in : mem[rd_ptr];
  assign pop       = dst_valid && link.dst_rdy_in;
  assign write_en  = push && !(pop && empty);
  assign read_en   = pop && !empty;
`else
  // Storage is not reset, so the head is forced to 0 while empty.
  assign dst_valid = !empty && !flush_in;
  assign dst_data  = empty ? '0 : mem[rd_ptr];
  assign pop       = dst_valid && link.dst_rdy_in;
  assign write_en  = push;
  assign read_en   = pop;
`endif

  assign link.src_rdy_out   = src_rdy;
  assign link.dst_valid_out = dst_valid;
  assign link.dst_data_out  = dst_data;
  assign count_out          = count_q;
  assign full_out           = full;
  assign empty_out          = empty;
  assign peak_out           = peak_q;

  stage_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clr_in   (flush_in),
    .inc_in   (write_en),
    .ptr_out  (wr_ptr)
  );

  stage_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .clr_in   (flush_in),
    .inc_in   (read_en),
    .ptr_out  (rd_ptr)
  );

  always_ff @(posedge clk_in) begin
    if (write_en) begin
      mem[wr_ptr] <= link.src_data_in;
    end
  end

  always_comb begin
    cnt_op = CNT_HOLD;
    if (flush_in) begin
      cnt_op = CNT_CLR;
    end else if (write_en && !read_en) begin
      cnt_op = CNT_INC;
    end else if (read_en && !write_en) begin
      cnt_op = CNT_DEC;
    end
  end

  always_comb begin
    count_next = count_q;
    case (cnt_op)
      CNT_INC: count_next = count_q + 1'b1;
      CNT_DEC: count_next = count_q - 1'b1;
      CNT_CLR: count_next = '0;
      default: count_next = count_q;
    endcase
  end

  // Flush leaves the high-water mark alone and overrides a peak clear.
  always_comb begin
    peak_next = peak_q;
    if (flush_in) begin
      peak_next = peak_q;
    end else if (peak_clr_in) begin
      peak_next = push ? count_next : '0;
    end else if (count_next > peak_q) begin
      peak_next = count_next;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      count_q <= count_next;
      peak_q  <= peak_next;
    end
  end

  a_no_push_full: assert property (@(posedge clk_in) disable iff (!reset_in)
    !(write_en && full));

  a_no_pop_empty: assert property (@(posedge clk_in) disable iff (!reset_in)
    !(read_en && empty));

  a_src_stable: assert property (@(posedge clk_in) disable iff (!reset_in)
    (link.src_valid_in && !src_rdy && !flush_in) |=>
      (!link.src_valid_in || $stable(link.src_data_in)));

endmodule

// File: tb/tb_stage_fifo.sv
// tb_stage_fifo
// Self-checking bench for stage_fifo: a DEPTH=4 instance checked against a
// queue-based reference model (directed scenarios plus random traffic) and a
// DEPTH=3 instance for streaming and pointer wrap.
// Honours STAGE_FIFO_BYPASS_EN in the same way as the design.
module tb_stage_fifo;

`ifdef STAGE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stage_fifo_if #(.DW(32)) lk4 ();
  stage_fifo_if #(.DW(32)) lk3 ();

  logic       flush4, clr4, flush3, clr3;
  logic [2:0] count4, peak4;
  logic       full4, empty4;
  logic [1:0] count3, peak3;
  logic       full3, empty3;

  stage_fifo #(.DW(32), .DEPTH(4)) dut4 (
    .clk_in      (clk),
    .reset_in    (rst_n),
    .flush_in    (flush4),
    .peak_clr_in (clr4),
    .link        (lk4),
    .count_out   (count4),
    .full_out    (full4),
    .empty_out   (empty4),
    .peak_out    (peak4)
  );

  stage_fifo #(.DW(32), .DEPTH(3)) dut3 (
    .clk_in      (clk),
    .reset_in    (rst_n),
    .flush_in    (flush3),
    .peak_clr_in (clr3),
    .link        (lk3),
    .count_out   (count3),
    .full_out    (full3),
    .empty_out   (empty3),
    .peak_out    (peak3)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of the DEPTH=4 instance: contents in order plus peak.
  logic [31:0] mq[$];
  int          mpeak = 0;

  function automatic bit m_rdy();
    return (mq.size() < 4) && !flush4;
  endfunction

  function automatic bit m_valid();
    return ((mq.size() > 0) || (BYP && lk4.src_valid_in)) && !flush4;
  endfunction

  function automatic logic [31:0] m_data();
    return (mq.size() > 0) ? mq[0] : lk4.src_data_in;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step4();
    bit has, push, pop;
    has  = mq.size() > 0;
    push = lk4.src_valid_in && m_rdy();
    pop  = m_valid() && lk4.dst_rdy_in;
    if (flush4) begin
      mq.delete();
    end else begin
      if (!(pop && !has)) begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(lk4.src_data_in);
      end
      if (clr4) mpeak = push ? mq.size() : 0;
      else if (mq.size() > mpeak) mpeak = mq.size();
    end
  endtask

  task automatic idle_inputs();
    lk4.src_valid_in = 1'b0; lk4.src_data_in = '0; lk4.dst_rdy_in = 1'b0;
    lk3.src_valid_in = 1'b0; lk3.src_data_in = '0; lk3.dst_rdy_in = 1'b0;
    flush4 = 1'b0; clr4 = 1'b0; flush3 = 1'b0; clr3 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    mpeak = 0;
    @(negedge clk);
    tests_run += 14;
    if (empty4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty4: got %b want 1", empty4); end
    if (lk4.dst_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid4: got %b want 0", lk4.dst_valid_out); end
    if (count4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count4: got %0d want 0", count4); end
    if (lk4.src_rdy_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rdy4: got %b want 1", lk4.src_rdy_out); end
    if (full4 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full4: got %b want 0", full4); end
    if (peak4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_peak4: got %0d want 0", peak4); end
    if (lk4.dst_data_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_data4: got %h want 0", lk4.dst_data_out); end
    if (empty3 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty3: got %b want 1", empty3); end
    if (lk3.dst_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid3: got %b want 0", lk3.dst_valid_out); end
    if (count3 !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_count3: got %0d want 0", count3); end
    if (lk3.src_rdy_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rdy3: got %b want 1", lk3.src_rdy_out); end
    if (full3 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full3: got %b want 0", full3); end
    if (peak3 !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_peak3: got %0d want 0", peak3); end
    if (lk3.dst_data_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_data3: got %h want 0", lk3.dst_data_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_transfer();
    for (int i = 0; i < 2; i++) begin
      lk4.src_valid_in = 1'b1; lk4.src_data_in = 32'h1000 + i;
      @(negedge clk);
      model_step4();
      @(posedge clk); #1;
    end
    lk4.src_valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run += 3;
    if (count4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL midreset_count: got %0d want 0", count4); end
    if (lk4.dst_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_valid: got %b want 0", lk4.dst_valid_out); end
    if (empty4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_empty: got %b want 1", empty4); end
    mq.delete();
    mpeak = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    int sent   = 0;
    int popped = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      lk4.src_valid_in = (sent < 5);
      lk4.src_data_in  = 32'hA0 + sent;
      lk4.dst_rdy_in   = (cyc >= 7);
      @(negedge clk);
      tests_run += 3;
      if (lk4.src_rdy_out !== m_rdy()) begin tests_failed++; $display("[TB] FAIL fill_rdy c%0d: got %b want %b", cyc, lk4.src_rdy_out, m_rdy()); end
      if (lk4.dst_valid_out !== m_valid()) begin tests_failed++; $display("[TB] FAIL fill_valid c%0d: got %b want %b", cyc, lk4.dst_valid_out, m_valid()); end
      if (count4 !== 3'(mq.size())) begin tests_failed++; $display("[TB] FAIL fill_count c%0d: got %0d want %0d", cyc, count4, mq.size()); end
      if (mq.size() == 4) begin
        tests_run += 2;
        if (full4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_full c%0d: got %b want 1", cyc, full4); end
        if (lk4.src_rdy_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_blocked c%0d: got %b want 0", cyc, lk4.src_rdy_out); end
      end
      if (m_valid() && lk4.dst_rdy_in) begin
        tests_run++;
        if (lk4.dst_data_out !== 32'hA0 + popped) begin tests_failed++; $display("[TB] FAIL drain_order %0d: got %h want %h", popped, lk4.dst_data_out, 32'hA0 + popped); end
        popped++;
      end
      if (m_rdy() && lk4.src_valid_in) sent++;
      model_step4();
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    tests_run += 2;
    if (peak4 !== 3'd4) begin tests_failed++; $display("[TB] FAIL drain_peak: got %0d want 4", peak4); end
    if (count4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL drain_count: got %0d want 0", count4); end
    model_step4();
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      lk4.src_valid_in = 1'b1; lk4.src_data_in = 32'hB0 + i; lk4.dst_rdy_in = 1'b0;
      @(negedge clk);
      model_step4();
      @(posedge clk); #1;
    end
    flush4 = 1'b1; lk4.src_valid_in = 1'b1; lk4.src_data_in = 32'h55; lk4.dst_rdy_in = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (lk4.src_rdy_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_rdy: got %b want 0", lk4.src_rdy_out); end
    if (lk4.dst_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_valid: got %b want 0", lk4.dst_valid_out); end
    model_step4();
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run += 4;
    if (count4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL flush_count: got %0d want 0", count4); end
    if (empty4 !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_empty: got %b want 1", empty4); end
    if (lk4.dst_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_no55: got %b want 0", lk4.dst_valid_out); end
    if (peak4 !== 3'd4) begin tests_failed++; $display("[TB] FAIL flush_peak: got %0d want 4", peak4); end
    model_step4();
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    lk4.src_valid_in = 1'b1; lk4.src_data_in = 32'h77; lk4.dst_rdy_in = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (lk4.dst_valid_out !== BYP) begin tests_failed++; $display("[TB] FAIL byp_valid0: got %b want %b", lk4.dst_valid_out, BYP); end
    if (count4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL byp_count0: got %0d want 0", count4); end
    if (m_valid()) begin
      tests_run++;
      if (lk4.dst_data_out !== 32'h77) begin tests_failed++; $display("[TB] FAIL byp_data0: got %h want 77", lk4.dst_data_out); end
    end
    model_step4();
    @(posedge clk); #1;
    lk4.src_valid_in = 1'b0; lk4.src_data_in = '0;
    @(negedge clk);
    tests_run += 2;
    if (lk4.dst_valid_out !== !BYP) begin tests_failed++; $display("[TB] FAIL byp_valid1: got %b want %b", lk4.dst_valid_out, !BYP); end
    if (count4 !== 3'(mq.size())) begin tests_failed++; $display("[TB] FAIL byp_count1: got %0d want %0d", count4, mq.size()); end
    if (m_valid()) begin
      tests_run++;
      if (lk4.dst_data_out !== 32'h77) begin tests_failed++; $display("[TB] FAIL byp_data1: got %h want 77", lk4.dst_data_out); end
    end
    model_step4();
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (count4 !== 3'd0) begin tests_failed++; $display("[TB] FAIL byp_count2: got %0d want 0", count4); end
    model_step4();
    @(posedge clk); #1;
  endtask

  task automatic test_peak_clear();
    lk4.src_valid_in = 1'b1; lk4.src_data_in = 32'hC1; lk4.dst_rdy_in = 1'b0;
    @(negedge clk);
    model_step4();
    @(posedge clk); #1;
    clr4 = 1'b1; lk4.src_data_in = 32'hC2;
    @(negedge clk);
    tests_run += 2;
    if (peak4 !== 3'd4) begin tests_failed++; $display("[TB] FAIL pclr_before: got %0d want 4", peak4); end
    if (count4 !== 3'd1) begin tests_failed++; $display("[TB] FAIL pclr_count1: got %0d want 1", count4); end
    model_step4();
    @(posedge clk); #1;
    clr4 = 1'b0; lk4.src_valid_in = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (peak4 !== 3'd2) begin tests_failed++; $display("[TB] FAIL pclr_after: got %0d want 2", peak4); end
    if (count4 !== 3'd2) begin tests_failed++; $display("[TB] FAIL pclr_count2: got %0d want 2", count4); end
    model_step4();
    @(posedge clk); #1;
    lk4.dst_rdy_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      model_step4();
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_random_traffic();
    bit hold = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        lk4.src_valid_in = ($urandom_range(0, 2) != 0);
        lk4.src_data_in  = $urandom;
      end
      lk4.dst_rdy_in = ((cyc / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush4 = ($urandom_range(0, 29) == 0);
      clr4   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      tests_run += 6;
      if (lk4.src_rdy_out !== m_rdy()) begin tests_failed++; $display("[TB] FAIL rnd_rdy c%0d: got %b want %b", cyc, lk4.src_rdy_out, m_rdy()); end
      if (lk4.dst_valid_out !== m_valid()) begin tests_failed++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", cyc, lk4.dst_valid_out, m_valid()); end
      if (count4 !== 3'(mq.size())) begin tests_failed++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", cyc, count4, mq.size()); end
      if (full4 !== (mq.size() == 4)) begin tests_failed++; $display("[TB] FAIL rnd_full c%0d: got %b want %b", cyc, full4, mq.size() == 4); end
      if (empty4 !== (mq.size() == 0)) begin tests_failed++; $display("[TB] FAIL rnd_empty c%0d: got %b want %b", cyc, empty4, mq.size() == 0); end
      if (peak4 !== 3'(mpeak)) begin tests_failed++; $display("[TB] FAIL rnd_peak c%0d: got %0d want %0d", cyc, peak4, mpeak); end
      if (m_valid()) begin
        tests_run++;
        if (lk4.dst_data_out !== m_data()) begin tests_failed++; $display("[TB] FAIL rnd_data c%0d: got %h want %h", cyc, lk4.dst_data_out, m_data()); end
      end
      hold = lk4.src_valid_in && !m_rdy();
      model_step4();
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_stream_wrap();
    logic [31:0] exp_q[$];
    bit          was_empty;
    bit          exp_valid;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      lk3.src_valid_in = (cyc < 100);
      lk3.src_data_in  = $urandom;
      lk3.dst_rdy_in   = 1'b1;
      @(negedge clk);
      was_empty = (exp_q.size() == 0);
      exp_valid = !was_empty || (BYP && lk3.src_valid_in);
      tests_run += 3;
      if (lk3.src_rdy_out !== 1'b1) begin tests_failed++; $display("[TB] FAIL str_rdy c%0d: got %b want 1", cyc, lk3.src_rdy_out); end
      if (lk3.dst_valid_out !== exp_valid) begin tests_failed++; $display("[TB] FAIL str_valid c%0d: got %b want %b", cyc, lk3.dst_valid_out, exp_valid); end
      if (count3 !== 2'(exp_q.size())) begin tests_failed++; $display("[TB] FAIL str_count c%0d: got %0d want %0d", cyc, count3, exp_q.size()); end
      if (exp_valid) begin
        tests_run++;
        if (lk3.dst_data_out !== (was_empty ? lk3.src_data_in : exp_q[0])) begin
          tests_failed++;
          $display("[TB] FAIL str_data c%0d: got %h want %h", cyc, lk3.dst_data_out, was_empty ? lk3.src_data_in : exp_q[0]);
        end
      end
      if (!(was_empty && BYP && lk3.src_valid_in)) begin
        if (!was_empty) void'(exp_q.pop_front());
        if (lk3.src_valid_in) exp_q.push_back(lk3.src_data_in);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (count3 !== 2'd0) begin tests_failed++; $display("[TB] FAIL str_final_count: got %0d want 0", count3); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_reset_mid_transfer();
    test_fill_drain();
    test_flush();
    test_bypass();
    test_peak_clear();
    test_random_traffic();
    test_stream_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
